// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN inference cores: kernel taps, widths, core state.
package cnn_pkg;

   localparam int KERNEL_LEN = 3;
   localparam int CONV_W     = 34;

   localparam logic signed [CONV_W-1:0] K0 = 34'sd1;
   localparam logic signed [CONV_W-1:0] K1 = 34'sd2;
   localparam logic signed [CONV_W-1:0] K2 = 34'sd1;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      DONE    = 2'd2
   } core_state_t;

endpackage

// File: rtl/cnn_core.sv
// Single-image core: capture, 3-tap conv + ReLU per cycle, global-sum pool.
// CNN_SATURATE_EN: accumulator clamps at all-ones instead of wrapping.
module cnn_core
   import cnn_pkg::*;
#(
   parameter int IMG_SIZE  = 64,
   parameter int OUT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          image [IMG_SIZE],
   output logic [OUT_WIDTH-1:0] prediction,
   output logic                 done
);

   localparam int IDX_W = $clog2(IMG_SIZE);
   localparam int SUM_W = ((OUT_WIDTH > CONV_W) ? OUT_WIDTH : CONV_W) + 1;

   core_state_t               r_state;
   core_state_t               w_next_state;
   logic [31:0]               r_buf [IMG_SIZE];
   logic [IDX_W-1:0]          r_idx;
   logic [IDX_W-1:0]          w_idx1;
   logic [IDX_W-1:0]          w_idx2;
   logic                      w_last;
   logic [OUT_WIDTH-1:0]      r_acc;
   logic [OUT_WIDTH-1:0]      w_acc_next;
   logic [OUT_WIDTH-1:0]      r_pred;
   logic                      r_done;
   logic signed [CONV_W-1:0]  w_conv_p0;
   logic signed [CONV_W-1:0]  w_relu_p0;

   function automatic logic signed [CONV_W-1:0] sext_px(input logic [31:0] px);
      return {{(CONV_W-32){px[31]}}, px};
   endfunction

   // relu is never negative, so it can be treated as an unsigned addend
   function automatic logic [OUT_WIDTH-1:0] acc_add(input logic [OUT_WIDTH-1:0] acc,
                                                    input logic [CONV_W-1:0]    relu);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(acc) + SUM_W'(relu);
`ifdef CNN_SATURATE_EN
      if (sum > SUM_W'({OUT_WIDTH{1'b1}}))
         return {OUT_WIDTH{1'b1}};
      return sum[OUT_WIDTH-1:0];
`else
      return sum[OUT_WIDTH-1:0];
`endif
   endfunction

   assign w_idx1 = r_idx + IDX_W'(1);
   assign w_idx2 = r_idx + IDX_W'(2);
   assign w_last = (r_idx == IDX_W'(IMG_SIZE - KERNEL_LEN));

   // stage p0: window convolution and ReLU, folded into the accumulator this cycle
   assign w_conv_p0  = K0 * sext_px(r_buf[r_idx])
                     + K1 * sext_px(r_buf[w_idx1])
                     + K2 * sext_px(r_buf[w_idx2]);
   assign w_relu_p0  = (w_conv_p0 > 0) ? w_conv_p0 : '0;
   assign w_acc_next = acc_add(r_acc, w_relu_p0);

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         LOAD:    w_next_state = COMPUTE;
         COMPUTE: if (w_last) w_next_state = DONE;
         DONE:    w_next_state = DONE;
         default: w_next_state = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= LOAD;
         r_idx   <= '0;
         r_acc   <= '0;
         r_pred  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            LOAD: r_idx <= '0;
            COMPUTE: begin
               r_acc <= w_acc_next;
               r_idx <= w_idx1;
               if (w_last) begin
                  r_pred <= w_acc_next;
                  r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // image data is only ever read after a LOAD edge, so it needs no reset
   always_ff @(posedge clk) begin
      if (r_state == LOAD)
         r_buf <= image;
   end

   assign prediction = r_pred;
   assign done       = r_done;

endmodule

// File: rtl/multi_core.sv
// Top-level compute block: N lockstep CNN cores, all_done when every core has finished.
// CNN_SATURATE_EN (see cnn_core) selects clamping instead of wrapping accumulators.
module multi_core
   import cnn_pkg::*;
#(
   parameter int IMG_SIZE  = 64,
   parameter int OUT_WIDTH = 32,
   parameter int N         = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          input_images [N][IMG_SIZE],
   output logic [OUT_WIDTH-1:0] predictions [N],
   output logic                 all_done
);

   logic [N-1:0] w_done;

   genvar g;
   generate
      for (g = 0; g < N; g++) begin : g_core
         cnn_core #(
            .IMG_SIZE  (IMG_SIZE),
            .OUT_WIDTH (OUT_WIDTH)
         ) u_core (
            .clk        (clk),
            .rst        (rst),
            .image      (input_images[g]),
            .prediction (predictions[g]),
            .done       (w_done[g])
         );
      end
   endgenerate

   assign all_done = &w_done;

endmodule

// File: tb/tb_multi_core.sv
// Directed self-checking bench for multi_core with default parameters.
module tb_multi_core;

   localparam int IMG = 64;
   localparam int NC  = 4;

   logic        clk;
   logic        rst;
   logic [31:0] imgs [NC][IMG];
   logic [31:0] preds [NC];
   logic        all_done;
   logic [31:0] exp_pred [NC];

   int n_cmp;
   int n_err;

   multi_core #(.IMG_SIZE(IMG), .OUT_WIDTH(32), .N(NC)) dut (
      .clk          (clk),
      .rst          (rst),
      .input_images (imgs),
      .predictions  (preds),
      .all_done     (all_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic fill_all(input logic [31:0] v);
      for (int j = 0; j < NC; j++)
         for (int i = 0; i < IMG; i++)
            imgs[j][i] = v;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Hold reset one edge, check cleared outputs, release, check done edge and results.
   task automatic do_run(input string name, input bit scramble);
      rst = 1'b1;
      step();
      chk({name, "_rst_done"}, {31'd0, all_done}, 32'd0);
      for (int j = 0; j < NC; j++)
         chk($sformatf("%s_rst_pred%0d", name, j), preds[j], 32'd0);
      rst = 1'b0;
      for (int e = 1; e <= IMG - 2; e++) begin
         step();
         if (scramble && e == 1)
            fill_all(32'h7FFF_FFFF);
      end
      chk({name, "_done_early"}, {31'd0, all_done}, 32'd0);
      chk({name, "_pred0_early"}, preds[0], 32'd0);
      step();
      chk({name, "_done_edge63"}, {31'd0, all_done}, 32'd1);
      for (int j = 0; j < NC; j++)
         chk($sformatf("%s_pred%0d", name, j), preds[j], exp_pred[j]);
      step();
      step();
      chk({name, "_done_hold"}, {31'd0, all_done}, 32'd1);
      chk({name, "_pred3_hold"}, preds[3], exp_pred[3]);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b1;
      fill_all(32'd0);
      step();
      step();
      chk("reset_done", {31'd0, all_done}, 32'd0);
      for (int j = 0; j < NC; j++)
         chk($sformatf("reset_pred%0d", j), preds[j], 32'd0);

      // all ones: 62 windows x 4
      fill_all(32'd1);
      for (int j = 0; j < NC; j++) exp_pred[j] = 32'd248;
      do_run("ones", 1'b0);

      // core j filled with j+1
      for (int j = 0; j < NC; j++) begin
         for (int i = 0; i < IMG; i++) imgs[j][i] = 32'(j + 1);
         exp_pred[j] = 32'(248 * (j + 1));
      end
      do_run("perc", 1'b0);

      // ramp, then inputs overwritten right after capture
      for (int j = 0; j < NC; j++) begin
         for (int i = 0; i < IMG; i++) imgs[j][i] = 32'(i);
         exp_pred[j] = 32'd7812;
      end
      do_run("ramp", 1'b1);

      // all -1: conv = -4, ReLU kills every window
      fill_all(32'hFFFF_FFFF);
      for (int j = 0; j < NC; j++) exp_pred[j] = 32'd0;
      do_run("neg", 1'b0);

      // 62 x 2^30 overflows 32 bits
      fill_all(32'h1000_0000);
`ifdef CNN_SATURATE_EN
      for (int j = 0; j < NC; j++) exp_pred[j] = 32'hFFFF_FFFF;
`else
      for (int j = 0; j < NC; j++) exp_pred[j] = 32'h8000_0000;
`endif
      do_run("big", 1'b0);

      // mid-run reset at edge 30, new data before release
      rst = 1'b1;
      step();
      fill_all(32'd1);
      rst = 1'b0;
      for (int e = 1; e <= 29; e++) step();
      rst = 1'b1;
      step();
      chk("mid_rst_done", {31'd0, all_done}, 32'd0);
      chk("mid_rst_pred0", preds[0], 32'd0);
      fill_all(32'd2);
      for (int j = 0; j < NC; j++) exp_pred[j] = 32'd496;
      do_run("mid", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
